// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the codec audio receive path.
package audio_pkg;

    localparam int unsigned DEF_BCLK_DIV = 2;
    localparam int unsigned DEF_SLOT_W   = 32;
    localparam int unsigned DEF_SAMPLE_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: registered bclk plus strobes flagging the clk_in edge
// on which bclk will rise or fall.
module i2s_bclk_gen
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic run,
    output logic bclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned HALF  = BCLK_DIV / 32'd2;
    localparam int unsigned CNT_W = cnt_width(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 32'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bclk_q, bclk_d;

    // Half-period counter; bclk parks low whenever the receiver is stopped.
    always_comb begin
        cnt_d    = cnt_q;
        bclk_d   = bclk_q;
        rise_stb = 1'b0;
        fall_stb = 1'b0;
        if (!run) begin
            cnt_d  = {CNT_W{1'b0}};
            bclk_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = {CNT_W{1'b0}};
            bclk_d   = ~bclk_q;
            rise_stb = ~bclk_q;
            fall_stb = bclk_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= {CNT_W{1'b0}};
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk = bclk_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S master receiver: drives BCLK/LRCLK to the codec, deserialises ADC data
// and hands stereo pairs downstream over valid/ready.
module i2s_adc_rx
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV = DEF_BCLK_DIV,
    parameter int unsigned SLOT_W   = DEF_SLOT_W,
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                adc_sdata,
    output logic                bclk,
    output logic                lrclk,
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun
);

    localparam int unsigned BIT_W = cnt_width(SLOT_W);
    localparam logic [BIT_W-1:0] LAST_SLOT_BIT   = BIT_W'(SLOT_W - 32'd1);
    localparam logic [BIT_W-1:0] FIRST_DATA_BIT  = BIT_W'(1);
    localparam logic [BIT_W-1:0] LAST_SAMPLE_BIT = BIT_W'(SAMPLE_W);

    i2s_state_e          state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                lrclk_q, lrclk_d;
    logic [SAMPLE_W-1:0] sh_l_q, sh_l_d;
    logic [SAMPLE_W-1:0] sh_r_q, sh_r_d;
    logic [SAMPLE_W-1:0] sample_l_q, sample_l_d;
    logic [SAMPLE_W-1:0] sample_r_q, sample_r_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic run_s;
    logic rise_stb_s;
    logic fall_stb_s;
    logic in_sample_s;
    logic wrap_s;
    logic frame_end_s;
    logic accept_s;

    assign run_s = (state_q == ST_RUN);

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .run      (run_s),
        .bclk     (bclk),
        .rise_stb (rise_stb_s),
        .fall_stb (fall_stb_s)
    );

    // Sequencing, capture and output handshake.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        sh_l_d     = sh_l_q;
        sh_r_d     = sh_r_q;
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        overrun_d  = overrun_q;

        // Bit 0 after each word-select edge is the I2S one-bit delay slot.
        in_sample_s = (bit_cnt_q >= FIRST_DATA_BIT) && (bit_cnt_q <= LAST_SAMPLE_BIT);
        wrap_s      = (bit_cnt_q == LAST_SLOT_BIT);
        frame_end_s = run_s && fall_stb_s && wrap_s && lrclk_q;
        accept_s    = valid_q && sample_ready;

        if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_RUN;
                    bit_cnt_d = {BIT_W{1'b0}};
                    lrclk_d   = 1'b0;
                    overrun_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rise_stb_s && in_sample_s) begin
                    if (lrclk_q) begin
                        sh_r_d = {sh_r_q[SAMPLE_W-2:0], adc_sdata};
                    end else begin
                        sh_l_d = {sh_l_q[SAMPLE_W-2:0], adc_sdata};
                    end
                end else begin
                    sh_l_d = sh_l_q;
                end

                if (fall_stb_s) begin
                    if (wrap_s) begin
                        bit_cnt_d = {BIT_W{1'b0}};
                        lrclk_d   = ~lrclk_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end

                // A full output register drops the new frame rather than the old one.
                if (frame_end_s) begin
                    if (!valid_q || accept_s) begin
                        sample_l_d = sh_l_q;
                        sample_r_d = sh_r_q;
                        valid_d    = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    if (enable) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= {BIT_W{1'b0}};
            lrclk_q    <= 1'b0;
            sh_l_q     <= {SAMPLE_W{1'b0}};
            sh_r_q     <= {SAMPLE_W{1'b0}};
            sample_l_q <= {SAMPLE_W{1'b0}};
            sample_r_q <= {SAMPLE_W{1'b0}};
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            sh_l_q     <= sh_l_d;
            sh_r_q     <= sh_r_d;
            sample_l_q <= sample_l_d;
            sample_r_q <= sample_r_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign lrclk        = lrclk_q;
    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: codec model plus frame-level reference feeding a
// scoreboard that a monitor drains on every accepted output pair.
module tb_i2s_adc_rx;

    localparam int SAMPLE_W = 16;
    localparam int SLOT_W   = 32;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        ones;
    } frame_t;

    logic                clk_in = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable = 1'b0;
    logic                adc_sdata = 1'b0;
    logic                sample_ready = 1'b0;
    logic                bclk;
    logic                lrclk;
    logic [SAMPLE_W-1:0] sample_l;
    logic [SAMPLE_W-1:0] sample_r;
    logic                sample_valid;
    logic                overrun;

    i2s_adc_rx #(.BCLK_DIV(2), .SLOT_W(SLOT_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .enable       (enable),
        .adc_sdata    (adc_sdata),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    always #5 clk_in = ~clk_in;

    frame_t      frame_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_acc = 0;

    // Reference state: what the codec is sending and what should come out.
    frame_t cur;
    logic   m_run = 1'b0, m_full = 1'b0, m_bprev = 1'b0, m_lr = 1'b0;
    logic   exp_overrun = 1'b0;
    logic   m_en, m_rdy, m_rst, fe, was_run;
    int     m_cnt = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic load_frame();
        if (frame_q.size() > 0) begin
            cur = frame_q.pop_front();
        end else begin
            cur.l    = 16'($urandom);
            cur.r    = 16'($urandom);
            cur.ones = 1'b0;
        end
    endtask

    function automatic logic codec_bit(input frame_t f, input logic lr, input int cnt);
        logic [15:0] w;
        w = lr ? f.r : f.l;
        if (cnt >= 1 && cnt <= SAMPLE_W) return w[SAMPLE_W - cnt];
        else if (f.ones) return 1'b1;
        else return 1'($urandom_range(1, 0));
    endfunction

    // Codec + frame-level expectation model, stepped once per clk_in.
    always begin
        @(posedge clk_in);
        m_en  = enable;
        m_rdy = sample_ready;
        m_rst = reset_n;
        #1;
        if (!m_rst) begin
            m_run = 1'b0; m_full = 1'b0; exp_overrun = 1'b0;
            m_cnt = 0; m_lr = 1'b0;
            exp_q.delete();
        end else begin
            was_run = m_run;
            fe = 1'b0;
            if (m_run && m_bprev && !bclk) begin
                if (m_cnt == SLOT_W - 1) begin
                    m_cnt = 0;
                    fe    = m_lr;
                    m_lr  = !m_lr;
                end else begin
                    m_cnt++;
                end
            end
            if (fe) begin
                if (!m_full || m_rdy) begin
                    exp_q.push_back({cur.l, cur.r});
                    m_full = 1'b1;
                end else begin
                    exp_overrun = 1'b1;
                end
                if (!m_en) m_run = 1'b0;
                else load_frame();
            end else if (m_full && m_rdy) begin
                m_full = 1'b0;
            end
            if (!was_run && m_en) begin
                m_run = 1'b1; exp_overrun = 1'b0;
                m_cnt = 0; m_lr = 1'b0;
                load_frame();
            end
        end
        m_bprev   = bclk;
        adc_sdata = m_run ? codec_bit(cur, m_lr, m_cnt) : 1'b0;
    end

    // Monitor: every accepted pair must match the scoreboard head.
    always begin
        @(negedge clk_in);
        if (reset_n && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_pair", {sample_l, sample_r}, 64'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk({sample_l, sample_r} == e, "pair_data", {sample_l, sample_r}, e);
            end
            n_acc++;
        end
    end

    task automatic wait_acc(input int target, input int budget, input string name);
        int t;
        t = 0;
        while (n_acc < target && t < budget) begin
            @(negedge clk_in);
            t++;
        end
        chk(n_acc >= target, name, n_acc, target);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int bad, tog, t, hi, target;
        logic prev;

        // Reset, then idle with enable low.
        repeat (3) @(posedge clk_in);
        #1 reset_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk_in);
            if (bclk || lrclk || sample_valid || overrun || sample_l != 16'd0 || sample_r != 16'd0) bad++;
        end
        chk(bad == 0, "idle_outputs_zero", bad, 0);

        // Basic frame followed by two backpressured frames.
        frame_q.push_back('{l: 16'hA5C3, r: 16'h1234, ones: 1'b0});
        frame_q.push_back('{l: 16'h7FFF, r: 16'h8000, ones: 1'b0});
        frame_q.push_back('{l: 16'h0001, r: 16'hFFFF, ones: 1'b0});
        @(posedge clk_in);
        #1 sample_ready = 1'b1; enable = 1'b1;
        repeat (4) @(negedge clk_in);
        tog = 0;
        prev = bclk;
        repeat (32) begin
            @(negedge clk_in);
            if (bclk != prev) tog++;
            prev = bclk;
        end
        chk(tog == 32, "bclk_period_2", tog, 32);
        t = 0;
        while (!lrclk && t < 200) begin @(negedge clk_in); t++; end
        hi = 0;
        while (lrclk && hi < 100) begin @(negedge clk_in); hi++; end
        chk(hi == 64, "lrclk_high_cycles", hi, 64);
        chk(sample_valid == 1'b1, "valid_at_lrclk_fall", sample_valid, 1);
        @(negedge clk_in);
        chk(sample_valid == 1'b0, "valid_one_cycle_pulse", sample_valid, 0);
        chk(n_acc == 1, "basic_frame_accepted", n_acc, 1);
        @(posedge clk_in);
        #1 sample_ready = 1'b0;

        repeat (270) @(negedge clk_in);
        chk(sample_valid == 1'b1, "held_valid", sample_valid, 1);
        chk({sample_l, sample_r} == 32'h7FFF8000, "held_pair", {sample_l, sample_r}, 32'h7FFF8000);
        chk(overrun == 1'b1, "overrun_set", overrun, 1);
        chk(overrun == exp_overrun, "overrun_model", overrun, exp_overrun);
        @(posedge clk_in);
        #1 sample_ready = 1'b1;
        repeat (3) @(negedge clk_in);
        chk(sample_valid == 1'b0, "valid_drop_after_accept", sample_valid, 0);
        chk(overrun == 1'b1, "overrun_sticky", overrun, 1);
        chk(exp_q.size() == 0, "dropped_frame_absent", exp_q.size(), 0);

        // Trailing slot bits driven high must not leak into the sample.
        target = n_acc + 2;
        frame_q.push_back('{l: 16'h0000, r: 16'h0000, ones: 1'b1});
        wait_acc(target, 400, "trailing_frame_timeout");

        // Graceful stop at left bit 10.
        t = 0;
        while (!(m_run && !m_lr && m_cnt == 10) && t < 300) begin @(negedge clk_in); t++; end
        chk(t < 300, "stop_point_reached", t, 300);
        enable = 1'b0;
        target = n_acc + 1;
        wait_acc(target, 300, "stop_frame_timeout");
        repeat (2) @(negedge clk_in);
        bad = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (bclk || lrclk) bad++;
        end
        chk(bad == 0, "stopped_clocks_low", bad, 0);
        chk(overrun == 1'b1, "overrun_kept_in_idle", overrun, 1);
        frame_q.push_back('{l: 16'h1357, r: 16'hBEEF, ones: 1'b0});
        target = n_acc + 1;
        @(posedge clk_in);
        #1 enable = 1'b1;
        repeat (3) @(negedge clk_in);
        chk(overrun == 1'b0, "overrun_cleared_on_restart", overrun, 0);
        wait_acc(target, 300, "restart_frame_timeout");

        // Asynchronous reset in the middle of the right slot.
        t = 0;
        while (!(m_run && m_lr && m_cnt == 8) && t < 300) begin @(negedge clk_in); t++; end
        chk(t < 300, "reset_point_reached", t, 300);
        #2 reset_n = 1'b0;
        #1;
        chk({bclk, lrclk, sample_valid, overrun, sample_l, sample_r} == 36'd0, "async_reset_outputs",
            {bclk, lrclk, sample_valid, overrun, sample_l, sample_r}, 0);
        frame_q.push_back('{l: 16'h0F0F, r: 16'hF0F0, ones: 1'b0});
        repeat (3) @(posedge clk_in);
        #1 reset_n = 1'b1;
        target = n_acc + 1;
        wait_acc(target, 300, "post_reset_frame_timeout");

        // Random traffic for a few frames, then a clean stop.
        target = n_acc + 4;
        wait_acc(target, 700, "random_frames_timeout");
        enable = 1'b0;
        repeat (300) @(negedge clk_in);
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        chk(bclk == 1'b0 && lrclk == 1'b0, "final_idle", {bclk, lrclk}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
